// File: rtl/serial_add_unit_if.sv
// Handshake/data bundle for serial_add_unit: start/operands in, busy/done/result out.
// SERIAL_ADD_SUB_EN adds the sub request bit alongside the operands.
interface serial_add_unit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, carry);
  modport slave  (input start, a, b, sub, output busy, done, sum, carry);
`else
  modport master (output start, a, b, input busy, done, sum, carry);
  modport slave  (input start, a, b, output busy, done, sum, carry);
`endif
endinterface

// File: rtl/serial_add_unit.sv
// Bit-serial adder: LSB-first, one bit per clock, registered carry, one-cycle done pulse.
// Optional macro SERIAL_ADD_SUB_EN enables subtraction (a - b) via the sub request bit.
module serial_add_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  serial_add_unit_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  // Full-adder cell: sum bit and next carry for the current LSB pair.
  logic s_bit;
  logic c_next;

  always_comb begin
    s_bit  = op_a[0] ^ op_b[0] ^ c;
    c_next = (op_a[0] & op_b[0]) | (op_a[0] & c) | (op_b[0] & c);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would chain shifts within one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      c       <= 1'b0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a   <= bus.a;
`ifdef SERIAL_ADD_SUB_EN
            // Two's complement subtract: a + ~b + 1.
            op_b   <= bus.sub ? ~bus.b : bus.b;
            c      <= bus.sub;
`else
            op_b   <= bus.b;
            c      <= 1'b0;
`endif
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end

        SHIFT: begin
          acc  <= {s_bit, acc[WIDTH-1:1]};
          op_a <= op_a >> 1;
          op_b <= op_b >> 1;
          c    <= c_next;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            sum_q   <= {s_bit, acc[WIDTH-1:1]};
            carry_q <= c_next;
            done_q  <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;

endmodule

// File: tb/tb_serial_add_unit.sv
// Self-checking bench for serial_add_unit (WIDTH=8): directed and random operations
// compared against a plain-arithmetic reference model.
module tb_serial_add_unit;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  serial_add_unit_if #(.WIDTH(WIDTH)) bus ();

  serial_add_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: {carry, sum} from plain arithmetic on the operands.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic s);
    logic [WIDTH-1:0] d;
    if (s) begin
      d = x - y;
      return {(x >= y), d};
    end
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic drive_sub(input logic s);
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = s;
`else
    if (s) $display("sub request ignored: feature disabled");
`endif
  endtask

  // Called 1 time unit after a rising edge with the DUT idle.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic sv, input string tag);
    logic [WIDTH:0] exp;
    int done_k;
    int pulses;
    exp = model(av, bv, sv);
    bus.start = 1'b1;
    bus.a = av;
    bus.b = bv;
    drive_sub(sv);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = WIDTH'($urandom);
    bus.b = WIDTH'($urandom);
    drive_sub(1'b0);
    check({tag, ".busy_start"}, 32'(bus.busy), 32'd1);
    done_k = -1;
    pulses = 0;
    for (int k = 1; k <= WIDTH + 2; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        pulses++;
        if (done_k < 0) done_k = k;
      end
      if (k == WIDTH) begin
        check({tag, ".sum"}, 32'(bus.sum), 32'(exp[WIDTH-1:0]));
        check({tag, ".carry"}, 32'(bus.carry), 32'(exp[WIDTH]));
      end
      if (k == WIDTH + 1) check({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
    end
    check({tag, ".done_at"}, 32'(done_k), 32'(WIDTH));
    check({tag, ".pulses"}, 32'(pulses), 32'd1);
  endtask

  initial begin
    int done_k1;
    int done_k2;
    int pulses;
    logic [WIDTH-1:0] sum1;
    logic [WIDTH-1:0] sum2;
    logic [WIDTH:0] exp;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic rs;

    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    drive_sub(1'b0);
    #1;
    check("reset0.busy", 32'(bus.busy), 32'd0);
    check("reset0.done", 32'(bus.done), 32'd0);
    check("reset0.sum", 32'(bus.sum), 32'd0);
    check("reset0.carry", 32'(bus.carry), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_op(8'h35, 8'h4A, 1'b0, "basic");
    run_op(8'hFF, 8'h01, 1'b0, "ovf1");
    run_op(8'hFF, 8'hFF, 1'b0, "ovf2");

    // Asynchronous reset mid-cycle with random inputs: outputs clear with no edge.
    @(posedge clk); #3;
    bus.a = WIDTH'($urandom);
    bus.b = WIDTH'($urandom);
    bus.start = 1'b1;
    reset = 1'b1;
    #1;
    check("async_rst.busy", 32'(bus.busy), 32'd0);
    check("async_rst.done", 32'(bus.done), 32'd0);
    check("async_rst.sum", 32'(bus.sum), 32'd0);
    check("async_rst.carry", 32'(bus.carry), 32'd0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Handshake: second start arrives while busy, is held, accepted at first IDLE edge.
    bus.start = 1'b1;
    bus.a = 8'h01;
    bus.b = 8'h02;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_k1 = -1;
    done_k2 = -1;
    pulses = 0;
    sum1 = '0;
    sum2 = '0;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        pulses++;
        if (done_k1 < 0) begin
          done_k1 = k;
          sum1 = bus.sum;
        end else begin
          done_k2 = k;
          sum2 = bus.sum;
        end
      end
      if (k == 2) begin
        bus.start = 1'b1;
        bus.a = 8'h10;
        bus.b = 8'h10;
      end
      if (k == 9) check("hs.busy_gap", 32'(bus.busy), 32'd0);
      if (k == 10) bus.start = 1'b0;
    end
    check("hs.sum1", 32'(sum1), 32'h03);
    check("hs.done1_at", 32'(done_k1), 32'd8);
    check("hs.sum2", 32'(sum2), 32'h20);
    check("hs.done2_at", 32'(done_k2), 32'd18);
    check("hs.pulses", 32'(pulses), 32'd2);
    check("hs.carry2", 32'(bus.carry), 32'd0);

    // Reset after three SHIFT edges: no done pulse, result cleared.
    bus.start = 1'b1;
    bus.a = 8'hAA;
    bus.b = 8'h77;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst.sum", 32'(bus.sum), 32'd0);
    check("mid_rst.busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < WIDTH + 2; k++) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    check("mid_rst.no_done", 32'(pulses), 32'd0);
    check("mid_rst.sum_hold", 32'(bus.sum), 32'd0);
    run_op(8'h0F, 8'h01, 1'b0, "after_rst");

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h10, 8'h01, 1'b1, "sub1");
    run_op(8'h01, 8'h02, 1'b1, "sub2");
`endif

    for (int i = 0; i < 20; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      exp = model(ra, rb, rs);
      run_op(ra, rb, rs, $sformatf("rand%0d", i));
      check($sformatf("rand%0d.hold", i), 32'({bus.carry, bus.sum}), 32'(exp));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
